// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - handshaked signed dot-product MAC sequencer with optional saturation
module mac_dot_seq #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic signed [2*IN_W-1:0] prod;
    logic                    p_vld;
    logic [LEN_W-1:0]        remaining;
    logic [ACC_W-1:0]        acc;
    logic                    ovf;

    logic                    accept;
    logic [ACC_W:0]          sum;
    logic                    sum_ovf;
    logic [ACC_W-1:0]        acc_next;

    assign accept = (state == RUN) && in_valid;

    // One guard bit above the accumulator: overflow shows as the top two bits disagreeing.
    always_comb begin
        sum      = {acc[ACC_W-1], acc}
                 + {{(ACC_W+1-2*IN_W){prod[2*IN_W-1]}}, prod};
        sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        acc_next = sum[ACC_W-1:0];
        if (SAT != 0 && sum_ovf) begin
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prod      <= '0;
            p_vld     <= 1'b0;
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (p_vld) begin
                acc <= acc_next;
                if (sum_ovf) ovf <= 1'b1;
            end
            p_vld <= accept;
            if (accept) prod <= $signed(a) * $signed(b);

            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        state     <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;
    assign overflow  = ovf;

endmodule
